// File: rtl/fifo_uart_tx.sv
// UART transmitter fed by an upstream FIFO. It issues one read per frame and serialises the byte 8N1, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        buf_empty,
  input  logic [7:0]  buf_out,
  output logic        rd_en,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] byte_count
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic bit_end;
  assign bit_end = (baud_cnt == BAUD_MAX);

  // NOTE: all state and outputs are updated with non-blocking assignments in one clocked
  // block, so every output is a register and nothing reads a half-updated value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      byte_count <= 16'd0;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      rd_en   <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= 3'd0;
          if (!buf_empty) begin
            state <= REQ;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        // Read data appears the cycle after the strobe, so REQ is a pure wait state.
        REQ: state <= LOAD;
        LOAD: begin
          shreg    <= buf_out;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit <= ^buf_out;
`endif
          tx       <= 1'b0;
          baud_cnt <= '0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_cnt   <= '0;
            busy       <= 1'b0;
            tx_done    <= 1'b1;
            byte_count <= byte_count + 16'd1;
            state      <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx at CLKS_PER_BIT=4: FIFO model, serial monitor with a
// byte scoreboard, a table of single-frame vectors and hand-written reset/back-to-back/wrap sequences.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int N = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * N;

  logic        clk;
  logic        rst;
  logic        buf_empty;
  logic [7:0]  buf_out;
  logic        rd_en;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [15:0] byte_count;

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .buf_empty (buf_empty),
    .buf_out   (buf_out),
    .rd_en     (rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  task automatic push_byte(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  // Upstream FIFO model: pops on a sampled read strobe, read data valid before the next edge.
  initial begin
    buf_empty = 1'b1;
    buf_out   = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1 && fifo_q.size() > 0) buf_out = fifo_q.pop_front();
      #1;
      buf_empty = (fifo_q.size() == 0);
    end
  end

  // Serial monitor
  int   cyc = 0;
  int   done_cnt = 0;
  int   rd_cnt = 0;
  int   last_len = 0;
  int   fall_q[$];
  logic mon_active = 1'b0;
  logic mon_pend = 1'b0;
  int   mon_pos = 0;
  int   mon_fall = 0;
  logic mon_samples[FRAME];
  logic last_parity = 1'b0;

  task automatic eval_frame();
    logic [7:0] exp_b;
    logic [7:0] got;
    logic       ideal;
    int         bad;
    int         bitno;
    if (exp_q.size() == 0) begin
      check("scoreboard_unexpected_frame", 32'd1, 32'd0);
      return;
    end
    exp_b = exp_q.pop_front();
    for (int k = 0; k < 8; k++) got[k] = mon_samples[(k + 1) * N + N / 2];
    check("rx_byte", {24'd0, got}, {24'd0, exp_b});
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      bitno = i / N;
      if (bitno == 0)                    ideal = 1'b0;
      else if (bitno <= 8)               ideal = exp_b[bitno - 1];
      else if (NBITS == 11 && bitno == 9) ideal = ^exp_b;
      else                               ideal = 1'b1;
      if (mon_samples[i] !== ideal) bad++;
    end
    check("waveform_bad_samples", bad, 0);
    last_parity = mon_samples[9 * N + N / 2];
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_done === 1'b1) done_cnt++;
      if (rd_en === 1'b1) rd_cnt++;
      if (rst === 1'b1) begin
        mon_active = 1'b0;
        mon_pend   = 1'b0;
      end else begin
        if (mon_pend) begin
          mon_pend = 1'b0;
          check("tx_done_at_frame_end", {31'd0, tx_done}, 32'd1);
          last_len = cyc - mon_fall;
        end
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1'b1;
          mon_pos    = 0;
          mon_fall   = cyc;
          fall_q.push_back(cyc);
        end
        if (mon_active) begin
          mon_samples[mon_pos] = tx;
          mon_pos++;
          if (mon_pos == FRAME) begin
            mon_active = 1'b0;
            mon_pend   = 1'b1;
            eval_frame();
          end
        end
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_done_within_budget", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        parity;
    logic [15:0] count;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int viol;
    int d0;
    int r0;
    int f0;
    int n;

    vecs[0] = '{data: 8'h07, parity: 1'b1, count: 16'd2};
    vecs[1] = '{data: 8'h03, parity: 1'b0, count: 16'd3};
    vecs[2] = '{data: 8'hC3, parity: 1'b0, count: 16'd4};
    vecs[3] = '{data: 8'h80, parity: 1'b1, count: 16'd5};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_rd_en", {31'd0, rd_en}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_tx_done", {31'd0, tx_done}, 32'd0);
    check("reset_byte_count", {16'd0, byte_count}, 32'd0);
    rst = 1'b0;

    // Quiet line with an empty FIFO
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0 || byte_count !== 16'd0) viol++;
    end
    check("idle_100_violations", viol, 0);

    // Single byte 0xA5 with exact read/start latency
    push_byte(8'hA5);
    @(negedge clk);
    check("a5_rd_en_after_e0", {31'd0, rd_en}, 32'd1);
    check("a5_busy_after_e0", {31'd0, busy}, 32'd1);
    check("a5_tx_high_e0", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("a5_rd_en_single", {31'd0, rd_en}, 32'd0);
    check("a5_tx_high_e1", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("a5_tx_low_e2", {31'd0, tx}, 32'd0);
    wait_done(1, FRAME + 10);
    check("a5_frame_len", last_len, FRAME);
    @(negedge clk);
    check("a5_tx_done_one_cycle", {31'd0, tx_done}, 32'd0);
    check("a5_busy_cleared", {31'd0, busy}, 32'd0);
    check("a5_byte_count", {16'd0, byte_count}, 32'd1);
    check("a5_rd_pulses", rd_cnt, 1);

    // Table of isolated frames
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      r0 = rd_cnt;
      push_byte(vecs[i].data);
      wait_done(d0 + 1, FRAME + 10);
      @(negedge clk);
      check("vec_frame_len", last_len, FRAME);
      check("vec_byte_count", {16'd0, byte_count}, {16'd0, vecs[i].count});
      check("vec_rd_pulses", rd_cnt - r0, 1);
      check("vec_busy_idle", {31'd0, busy}, 32'd0);
`ifdef FIFO_UART_TX_PARITY_EN
      check("vec_parity_bit", {31'd0, last_parity}, {31'd0, vecs[i].parity});
`endif
    end

    // Reset in DATA bit 3 of 0x55 aborts the frame
    d0 = done_cnt;
    r0 = rd_cnt;
    push_byte(8'h55);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_tx_fall_seen", {31'd0, tx}, 32'd0);
    repeat (4 * N + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_high_at_reset", {31'd0, tx}, 32'd1);
    check("abort_busy_at_reset", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (60) @(negedge clk);
    check("abort_no_tx_done", done_cnt - d0, 0);
    check("abort_byte_count", {16'd0, byte_count}, 32'd0);
    check("abort_busy_idle", {31'd0, busy}, 32'd0);
    check("abort_tx_idle", {31'd0, tx}, 32'd1);
    check("abort_rd_pulses", rd_cnt - r0, 1);

    // Reset on the same edge that sees a non-empty FIFO
    r0 = rd_cnt;
    push_byte(8'h11);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wins_rd_en", {31'd0, rd_en}, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_wins_no_read", rd_cnt - r0, 0);
    check("rst_wins_busy", {31'd0, busy}, 32'd0);

    // Three queued bytes, back to back
    d0 = done_cnt;
    r0 = rd_cnt;
    f0 = fall_q.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    wait_done(d0 + 3, 3 * (FRAME + 10));
    @(negedge clk);
    check("b2b_byte_count", {16'd0, byte_count}, 32'd3);
    check("b2b_rd_pulses", rd_cnt - r0, 3);
    check("b2b_frames", fall_q.size() - f0, 3);
    if (fall_q.size() >= f0 + 3) begin
      check("b2b_spacing_1", fall_q[f0 + 1] - fall_q[f0], FRAME + 3);
      check("b2b_spacing_2", fall_q[f0 + 2] - fall_q[f0 + 1], FRAME + 3);
    end
    check("b2b_frame_len", last_len, FRAME);

    // byte_count wraps from 0xFFFF
    @(negedge clk);
    force dut.byte_count = 16'hFFFF;
    @(negedge clk);
    release dut.byte_count;
    @(negedge clk);
    check("wrap_preload", {16'd0, byte_count}, 32'h0000FFFF);
    d0 = done_cnt;
    push_byte(8'h81);
    wait_done(d0 + 1, FRAME + 10);
    @(negedge clk);
    check("wrap_byte_count", {16'd0, byte_count}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
